// File: rtl/lu_arbiter_pkg.sv
// Shared definitions for the two-requester logical-unit arbiter:
// op-code constants, output-slot FSM encoding and the default datapath width.
package lu_arbiter_pkg;

    localparam int DATA_W_DEF = 32;

    // Operation select codes presented on reqX_sel
    typedef enum logic [1:0] {
        OP_XOR = 2'b00,
        OP_NOT = 2'b01,
        OP_OR  = 2'b10,
        OP_AND = 2'b11
    } op_e;

    // Output slot occupancy
    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/lu_arbiter_if.sv
// Bundle of the two request channels, the result channel and the transfer
// counter. The arbiter takes the slave view; the producer/consumer side
// takes the master view.
interface lu_arbiter_if #(
    parameter int DATA_W = lu_arbiter_pkg::DATA_W_DEF
);
    logic              req0_valid;
    logic              req0_ready;
    logic [1:0]        req0_sel;
    logic [DATA_W-1:0] req0_a;
    logic [DATA_W-1:0] req0_b;

    logic              req1_valid;
    logic              req1_ready;
    logic [1:0]        req1_sel;
    logic [DATA_W-1:0] req1_a;
    logic [DATA_W-1:0] req1_b;

    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_data;
    logic              res_id;
    logic [15:0]       op_count;

    modport slave (
        input  req0_valid, req0_sel, req0_a, req0_b,
        input  req1_valid, req1_sel, req1_a, req1_b,
        input  res_ready,
        output req0_ready, req1_ready,
        output res_valid, res_data, res_id, op_count
    );

    modport master (
        output req0_valid, req0_sel, req0_a, req0_b,
        output req1_valid, req1_sel, req1_a, req1_b,
        output res_ready,
        input  req0_ready, req1_ready,
        input  res_valid, res_data, res_id, op_count
    );
endinterface

// File: rtl/lu_arbiter_logical_unit.sv
// Combinational bitwise logic unit: XOR, NOT(A), OR, AND selected by sel.
module logical_unit
    import lu_arbiter_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [1:0]        sel,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] y
);

    // Pick the bitwise function for the current op code
    always_comb begin
        y = '0;
        case (sel)
            OP_XOR:  y = a ^ b;
            OP_NOT:  y = ~a;
            OP_OR:   y = a | b;
            OP_AND:  y = a & b;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/lu_arbiter.sv
// Round-robin arbiter in front of a single logical unit. One granted request
// per cycle is evaluated and captured into a one-entry result slot; the slot
// can be drained and refilled on the same edge for full throughput.
module lu_arbiter
    import lu_arbiter_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    lu_arbiter_if.slave bus
);

    slot_state_e       state;
    logic              last_grant;
    logic [DATA_W-1:0] res_data_q;
    logic              res_id_q;
    logic [15:0]       op_count_q;

    logic              slot_free;
    logic              pick0;
    logic              pick1;
    logic              grant0;
    logic              grant1;
    logic              grant_any;
    logic              res_xfer;
    logic [1:0]        mux_sel;
    logic [DATA_W-1:0] mux_a;
    logic [DATA_W-1:0] mux_b;
    logic [DATA_W-1:0] lu_y;

    // Grant decision: depends only on valids, pointer, slot state and res_ready,
    // never on operands. Held off while reset is asserted.
    always_comb begin
        slot_free = (state == S_EMPTY) || bus.res_ready;
        pick0     = bus.req0_valid && (!bus.req1_valid || last_grant);
        pick1     = bus.req1_valid && (!bus.req0_valid || !last_grant);
        grant0    = rst_n && slot_free && pick0;
        grant1    = rst_n && slot_free && pick1;
        grant_any = grant0 || grant1;
        res_xfer  = (state == S_FULL) && bus.res_ready;
    end

    // Steer the granted requester's operands into the logic unit
    always_comb begin
        mux_sel = grant1 ? bus.req1_sel : bus.req0_sel;
        mux_a   = grant1 ? bus.req1_a   : bus.req0_a;
        mux_b   = grant1 ? bus.req1_b   : bus.req0_b;
    end

    logical_unit #(.DATA_W(DATA_W)) u_lu (
        .sel (mux_sel),
        .a   (mux_a),
        .b   (mux_b),
        .y   (lu_y)
    );

    // Result slot FSM, round-robin pointer and transfer counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_EMPTY;
            res_data_q <= '0;
            res_id_q   <= 1'b0;
            last_grant <= 1'b1;
            op_count_q <= 16'h0000;
        end else begin
            if (res_xfer)
                op_count_q <= op_count_q + 16'h0001;
            if (grant_any) begin
                state      <= S_FULL;
                res_data_q <= lu_y;
                res_id_q   <= grant1;
                last_grant <= grant1;
            end else if (res_xfer) begin
                state <= S_EMPTY;
            end
        end
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.res_valid  = (state == S_FULL);
    assign bus.res_data   = res_data_q;
    assign bus.res_id     = res_id_q;
    assign bus.op_count   = op_count_q;

endmodule

// File: tb/tb_lu_arbiter.sv
// Directed bench for lu_arbiter: inputs change on the falling edge, ready is
// checked 1 time unit later, registered outputs on the following falling edge.
module tb_lu_arbiter;

    logic clk;
    logic rst_n;
    int   n_total;
    int   n_pass;

    lu_arbiter_if #(.DATA_W(32)) bus ();

    lu_arbiter #(.DATA_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        rst_n   = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_sel = 2'b00; bus.req0_a = '0; bus.req0_b = '0;
        bus.req1_valid = 1'b1; bus.req1_sel = 2'b00; bus.req1_a = '0; bus.req1_b = '0;
        bus.res_ready  = 1'b1;

        // Reset: no grants even with both valid, outputs cleared
        repeat (2) @(negedge clk);
        chk("rst_ready0", {31'd0, bus.req0_ready}, 32'd0);
        chk("rst_ready1", {31'd0, bus.req1_ready}, 32'd0);
        chk("rst_valid",  {31'd0, bus.res_valid}, 32'd0);
        chk("rst_data",   bus.res_data, 32'h0);
        chk("rst_id",     {31'd0, bus.res_id}, 32'd0);
        chk("rst_count",  {16'd0, bus.op_count}, 32'd0);

        // req0 only, AND
        bus.req1_valid = 1'b0;
        bus.req0_sel = 2'b11; bus.req0_a = 32'hF0F0F0F0; bus.req0_b = 32'hFF00FF00;
        rst_n = 1'b1;
        #1;
        chk("and_ready0", {31'd0, bus.req0_ready}, 32'd1);
        chk("and_ready1", {31'd0, bus.req1_ready}, 32'd0);
        @(negedge clk);
        chk("and_valid", {31'd0, bus.res_valid}, 32'd1);
        chk("and_data",  bus.res_data, 32'hF000F000);
        chk("and_id",    {31'd0, bus.res_id}, 32'd0);
        chk("and_count0", {16'd0, bus.op_count}, 32'd0);
        bus.req0_valid = 1'b0;
        #1;
        chk("idle_ready0", {31'd0, bus.req0_ready}, 32'd0);
        @(negedge clk);
        chk("and_drained", {31'd0, bus.res_valid}, 32'd0);
        chk("and_count1", {16'd0, bus.op_count}, 32'd1);

        // req1 only: NOT then back-to-back XOR
        bus.req1_valid = 1'b1; bus.req1_sel = 2'b01; bus.req1_a = 32'h0000FFFF; bus.req1_b = 32'h12345678;
        #1;
        chk("not_ready1", {31'd0, bus.req1_ready}, 32'd1);
        chk("not_ready0", {31'd0, bus.req0_ready}, 32'd0);
        @(negedge clk);
        chk("not_data", bus.res_data, 32'hFFFF0000);
        chk("not_id",   {31'd0, bus.res_id}, 32'd1);
        bus.req1_sel = 2'b00; bus.req1_a = 32'hA5A5A5A5; bus.req1_b = 32'hA5A5A5A5;
        #1;
        chk("xor_ready1_full", {31'd0, bus.req1_ready}, 32'd1);
        @(negedge clk);
        chk("xor_valid", {31'd0, bus.res_valid}, 32'd1);
        chk("xor_data",  bus.res_data, 32'h00000000);
        chk("xor_count", {16'd0, bus.op_count}, 32'd2);
        bus.req1_valid = 1'b0;
        @(negedge clk);
        chk("xor_count3", {16'd0, bus.op_count}, 32'd3);

        // Both valid, OR ops: alternate 0,1,0,1, one result per cycle
        bus.req0_valid = 1'b1; bus.req0_sel = 2'b10; bus.req0_a = 32'h1;  bus.req0_b = 32'h2;
        bus.req1_valid = 1'b1; bus.req1_sel = 2'b10; bus.req1_a = 32'h10; bus.req1_b = 32'h20;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_ready0", {31'd0, bus.req0_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("rr_ready1", {31'd0, bus.req1_ready}, (i % 2 == 0) ? 32'd0 : 32'd1);
            @(negedge clk);
            chk("rr_id",    {31'd0, bus.res_id}, (i % 2 == 0) ? 32'd0 : 32'd1);
            chk("rr_data",  bus.res_data, (i % 2 == 0) ? 32'h3 : 32'h30);
            chk("rr_count", {16'd0, bus.op_count}, 32'd3 + 32'(i));
        end
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        @(negedge clk);
        chk("rr_empty", {31'd0, bus.res_valid}, 32'd0);
        chk("rr_count7", {16'd0, bus.op_count}, 32'd7);

        // Backpressure: hold a req0 result, both valid, readys must stay low
        bus.res_ready = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_sel = 2'b11; bus.req0_a = 32'hFFFFFFFF; bus.req0_b = 32'h12345678;
        #1;
        chk("bp_grant0", {31'd0, bus.req0_ready}, 32'd1);
        @(negedge clk);
        bus.req1_valid = 1'b1; bus.req1_sel = 2'b00; bus.req1_a = 32'hFF; bus.req1_b = 32'h0F;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_ready0", {31'd0, bus.req0_ready}, 32'd0);
            chk("bp_ready1", {31'd0, bus.req1_ready}, 32'd0);
            @(negedge clk);
            chk("bp_data",  bus.res_data, 32'h12345678);
            chk("bp_id",    {31'd0, bus.res_id}, 32'd0);
            chk("bp_valid", {31'd0, bus.res_valid}, 32'd1);
            chk("bp_count", {16'd0, bus.op_count}, 32'd7);
        end
        bus.res_ready = 1'b1;
        #1;
        chk("rel_ready1", {31'd0, bus.req1_ready}, 32'd1);
        chk("rel_ready0", {31'd0, bus.req0_ready}, 32'd0);
        @(negedge clk);
        chk("rel_data",  bus.res_data, 32'h000000F0);
        chk("rel_id",    {31'd0, bus.res_id}, 32'd1);
        chk("rel_count", {16'd0, bus.op_count}, 32'd8);

        // Reset while FULL: result discarded, tie afterwards goes to req0
        bus.res_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mr_ready0", {31'd0, bus.req0_ready}, 32'd0);
        chk("mr_ready1", {31'd0, bus.req1_ready}, 32'd0);
        @(negedge clk);
        chk("mr_valid", {31'd0, bus.res_valid}, 32'd0);
        chk("mr_count", {16'd0, bus.op_count}, 32'd0);
        chk("mr_data",  bus.res_data, 32'h0);
        rst_n = 1'b1;
        bus.res_ready = 1'b1;
        #1;
        chk("mr_tie0", {31'd0, bus.req0_ready}, 32'd1);
        chk("mr_tie1", {31'd0, bus.req1_ready}, 32'd0);
        @(negedge clk);
        chk("mr_id",   {31'd0, bus.res_id}, 32'd0);
        chk("mr_res",  bus.res_data, 32'h12345678);

        // Counter wrap: req0 only streams one transfer per cycle
        bus.req1_valid = 1'b0;
        repeat (65535) @(negedge clk);
        chk("wrap_ffff", {16'd0, bus.op_count}, 32'h0000FFFF);
        chk("wrap_valid", {31'd0, bus.res_valid}, 32'd1);
        @(negedge clk);
        chk("wrap_zero", {16'd0, bus.op_count}, 32'h00000000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
